// File: rtl/fadd_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (align, add, normalise), valid/ready.
// Define FADD_PIPE_FLAGS_EN to add registered o_zero/o_ovf/o_unf result flags.
module fadd_pipe #(
    parameter int unsigned FRAC_WIDTH = 40,
    parameter int unsigned EXP_WIDTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic                        i_sub,
    input  logic                        i_sign_a,
    input  logic signed [EXP_WIDTH-1:0] i_exp_a,
    input  logic [FRAC_WIDTH-1:0]       i_frac_a,
    input  logic                        i_sign_b,
    input  logic signed [EXP_WIDTH-1:0] i_exp_b,
    input  logic [FRAC_WIDTH-1:0]       i_frac_b,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_sign_c,
    output logic signed [EXP_WIDTH-1:0] o_exp_c,
    output logic [FRAC_WIDTH-1:0]       o_frac_c
`ifdef FADD_PIPE_FLAGS_EN
    ,
    output logic                        o_zero,
    output logic                        o_ovf,
    output logic                        o_unf
`endif
);
    localparam int FW = int'(FRAC_WIDTH);
    localparam int EW = int'(EXP_WIDTH);
    localparam int GW = FW + 2;
    localparam int SW = FW + 3;
    localparam logic signed [EW-1:0] EXP_MAX = {1'b0, {(EW-1){1'b1}}};
    localparam logic signed [EW-1:0] EXP_MIN = {1'b1, {(EW-1){1'b0}}};

    logic w_en1, w_en2, w_en3;

    logic                 r_s1_valid, r_s1_sign_l, r_s1_sign_s;
    logic signed [EW-1:0] r_s1_exp;
    logic [GW-1:0]        r_s1_frac_l, r_s1_frac_s;

    logic                 r_s2_valid, r_s2_sign;
    logic signed [EW-1:0] r_s2_exp;
    logic [SW-1:0]        r_s2_sum;

    logic                 r_s3_valid, r_sign_c;
    logic signed [EW-1:0] r_exp_c;
    logic [FW-1:0]        r_frac_c;

    // A stage may load when empty or when its occupant leaves on the same edge.
    always_comb begin
        w_en3 = ~r_s3_valid | i_ready;
        w_en2 = ~r_s2_valid | w_en3;
        w_en1 = ~r_s1_valid | w_en2;
    end

    assign o_ready  = w_en1;
    assign o_valid  = r_s3_valid;
    assign o_sign_c = r_sign_c;
    assign o_exp_c  = r_exp_c;
    assign o_frac_c = r_frac_c;

    logic                 w_sign_b, w_a_large;
    logic signed [EW:0]   w_ediff;
    logic [EW:0]          w_d;
    logic [GW-1:0]        w_ext_s, w_shift_s;

    // A zero-mantissa operand is never chosen as large, so it contributes exactly nothing.
    always_comb begin
        w_sign_b = i_sign_b ^ i_sub;
        w_ediff  = {i_exp_a[EW-1], i_exp_a} - {i_exp_b[EW-1], i_exp_b};
        if (i_frac_b == '0) begin
            w_a_large = 1'b1;
        end else if (i_frac_a == '0) begin
            w_a_large = 1'b0;
        end else begin
            w_a_large = ~w_ediff[EW];
        end
        w_d       = w_ediff[EW] ? $unsigned(-w_ediff) : $unsigned(w_ediff);
        w_ext_s   = w_a_large ? {i_frac_b, 2'b00} : {i_frac_a, 2'b00};
        w_shift_s = (32'(w_d) >= GW) ? '0 : (w_ext_s >> w_d);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign_l <= 1'b0;
            r_s1_sign_s <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_frac_l <= '0;
            r_s1_frac_s <= '0;
        end else if (w_en1) begin
            r_s1_valid  <= i_valid;
            r_s1_sign_l <= w_a_large ? i_sign_a : w_sign_b;
            r_s1_sign_s <= w_a_large ? w_sign_b : i_sign_a;
            r_s1_exp    <= w_a_large ? i_exp_a : i_exp_b;
            r_s1_frac_l <= w_a_large ? {i_frac_a, 2'b00} : {i_frac_b, 2'b00};
            r_s1_frac_s <= w_shift_s;
        end
    end

    logic          w_eq_sign, w_neg;
    logic [SW-1:0] w_raw;

    always_comb begin
        w_eq_sign = (r_s1_sign_l == r_s1_sign_s);
        w_raw     = w_eq_sign ? ({1'b0, r_s1_frac_l} + {1'b0, r_s1_frac_s})
                              : ({1'b0, r_s1_frac_l} - {1'b0, r_s1_frac_s});
        w_neg     = ~w_eq_sign & w_raw[SW-1];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_sum   <= '0;
        end else if (w_en2) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= w_neg ? r_s1_sign_s : r_s1_sign_l;
            r_s2_exp   <= r_s1_exp;
            r_s2_sum   <= w_neg ? (~w_raw + 1'b1) : w_raw;
        end
    end

    int                   w_lzc, w_exp_n;
    logic                 w_sign_n;
    logic signed [EW-1:0] w_exp_c;
    logic [FW-1:0]        w_frac_c;
`ifdef FADD_PIPE_FLAGS_EN
    logic w_zero, w_ovf, w_unf;
`endif

    // Bit SW-1 is the carry, bits [1:0] are guard bits dropped by truncation.
    always_comb begin
        w_lzc = GW;
        for (int i = 0; i < GW; i++) begin
            if (r_s2_sum[i]) w_lzc = GW - 1 - i;
        end
        w_exp_n  = r_s2_sum[SW-1] ? int'(r_s2_exp) + 1 : int'(r_s2_exp) - w_lzc;
        w_frac_c = r_s2_sum[SW-1] ? r_s2_sum[SW-1:3]
                                  : FW'((r_s2_sum[GW-1:0] << w_lzc) >> 2);
        w_sign_n = r_s2_sign;
        w_exp_c  = EW'(w_exp_n);
`ifdef FADD_PIPE_FLAGS_EN
        w_zero = 1'b0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
`endif
        if (r_s2_sum == '0 || w_exp_n < int'(EXP_MIN)) begin
`ifdef FADD_PIPE_FLAGS_EN
            w_zero = 1'b1;
            w_unf  = (r_s2_sum != '0);
`endif
            w_sign_n = 1'b0;
            w_exp_c  = EXP_MIN;
            w_frac_c = '0;
        end else if (w_exp_n > int'(EXP_MAX)) begin
`ifdef FADD_PIPE_FLAGS_EN
            w_ovf = 1'b1;
`endif
            w_exp_c  = EXP_MAX;
            w_frac_c = '1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s3_valid <= 1'b0;
            r_sign_c   <= 1'b0;
            r_exp_c    <= '0;
            r_frac_c   <= '0;
        end else if (w_en3) begin
            r_s3_valid <= r_s2_valid;
            r_sign_c   <= w_sign_n;
            r_exp_c    <= w_exp_c;
            r_frac_c   <= w_frac_c;
        end
    end

`ifdef FADD_PIPE_FLAGS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_zero <= 1'b0;
            o_ovf  <= 1'b0;
            o_unf  <= 1'b0;
        end else if (w_en3) begin
            o_zero <= w_zero;
            o_ovf  <= w_ovf;
            o_unf  <= w_unf;
        end
    end
`endif

endmodule

// File: doc/fadd_pipe.md
FADD_PIPE -- requirements
Module: fadd_pipe

Interface
REQ-001 Parameter FRAC_WIDTH, default 40: mantissa width; MSB is the explicit leading one; value = (-1)^sign * frac * 2^(exp-(FRAC_WIDTH-1)).
REQ-002 Parameter EXP_WIDTH, default 8: signed two's-complement exponent width.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous and active-low.
REQ-005 i_valid  input  1  operand pair valid.
REQ-006 o_ready  output  1  block accepts operands this cycle.
REQ-007 i_sub  input  1  0 = A+B, 1 = A-B.
REQ-008 i_sign_a / i_exp_a / i_frac_a  input  1 / EXP_WIDTH signed / FRAC_WIDTH  operand A.
REQ-009 i_sign_b / i_exp_b / i_frac_b  input  1 / EXP_WIDTH signed / FRAC_WIDTH  operand B.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  downstream accepts result.
REQ-012 o_sign_c / o_exp_c / o_frac_c  output  1 / EXP_WIDTH signed / FRAC_WIDTH  result.

Function
REQ-013 Three registered stages S1 align, S2 add, S3 normalise; each holds a valid bit; latency 3 cycles from accept to o_valid with i_ready held 1; throughput 1 result/cycle.
REQ-014 Transfer in: i_valid & o_ready; transfer out: o_valid & i_ready.
REQ-015 Stage k loads when empty or when its content moves on the same cycle; o_ready = ~S1_valid | S1 advances (combinational from i_ready, no skid buffer).
REQ-016 While o_valid=1 and i_ready=0, all o_* outputs are held stable and no stage content is lost or duplicated.
REQ-017 S1: effective sign_b = i_sign_b ^ i_sub; select larger-exponent operand as large (ties: A large); d = |exp_a - exp_b| computed in EXP_WIDTH+1 bits.
REQ-018 S1: small mantissa extended by 2 guard bits, shifted right by d; d >= FRAC_WIDTH+2 gives zero.
REQ-019 S2: add (signs equal) or subtract (signs differ) in FRAC_WIDTH+3 bits; negative difference is negated and result sign taken from the small operand; otherwise sign of large operand.
REQ-020 S3: carry out -> shift right 1, exp+1; else shift left by leading-zero count, exp-lzc; guard bits truncated (round toward zero).
REQ-021 Zero mantissa result: o_frac_c=0, o_exp_c=-2^(EXP_WIDTH-1), o_sign_c=0.
REQ-022 Exponent above 2^(EXP_WIDTH-1)-1: saturate to max exp, frac all ones, sign kept; below minimum: flush to zero per REQ-021.
REQ-023 Zero-mantissa input operand is treated as exact zero regardless of its exponent; result equals the other operand (sign per i_sub).

Reset
REQ-024 While i_rst_n=0 at a rising edge: all stage valid bits clear, o_valid=0, o_sign_c=0, o_exp_c=0, o_frac_c=0; in-flight operations discarded.
REQ-025 o_ready=1 in the first cycle after i_rst_n returns to 1.

Configuration
REQ-026 Macro FADD_PIPE_FLAGS_EN defined: outputs o_zero, o_ovf, o_unf (1 bit each) are present, registered with and aligned to the result, reset 0, set per REQ-021/REQ-022.
REQ-027 Macro undefined: these ports and their logic are absent; arithmetic and timing unchanged.

Verification (FRAC_WIDTH=40, EXP_WIDTH=8; 1.0 = frac 0x8000000000 exp 0)
REQ-028 1.0 + 1.0, i_ready=1 -> o_valid on cycle 3, frac 0x8000000000, exp 1, sign 0.
REQ-029 1.0 - 0.75 (0.75 = frac 0xC000000000 exp -1) -> frac 0x8000000000, exp -2, sign 0.
REQ-030 1.5 - 1.5 (frac 0xC000000000 exp 0) -> frac 0, exp -128, sign 0; o_zero=1 with FADD_PIPE_FLAGS_EN.
REQ-031 Stream 5 back-to-back ops, i_ready=0 for cycles 4-7 -> o_ready drops once the pipe is full, outputs stable, all 5 results emitted in order, none lost.
REQ-032 Max exp 127, frac 0xFFFFFFFFFF added to itself -> exp 127, frac 0xFFFFFFFFFF; o_ovf=1 with macro defined.
REQ-033 Assert i_rst_n=0 for one cycle with 2 ops in flight -> o_valid=0 next cycle, no stale result emitted afterwards.
